sprite_draw_ctrl: RTL and testbench
===================================

// Module: sprite_draw_ctrl
// PURPOSE
//  Sequencer for the pixel-plot datapath: moves one SPR_W x SPR_H box sprite per frame.
//  Each move erases the sprite, probes the target footprint via color_obs and redraws it
//  (moved, or in place if blocked). Sits between processor-level control and the frame buffer.
//  Drives x/y/color_draw/plot one pixel per clk.
// PARAMETERS
//  SPR_W     4      sprite width in pixels (1..16)
//  SPR_H     4      sprite height in pixels (1..16)
//  X_MAX     159    last valid screen column
//  Y_MAX     119    last valid screen row
//  BG_COLOR  8'h00  erase colour; any other probed colour is an obstacle
//  FG_COLOR  8'hE0  sprite colour
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-low reset
//  start       in   1  level; in IDLE, high starts a session at current position
//  stop        in   1  level; sampled only in WAIT; high -> IDLE, sprite left drawn
//  frame_tick  in   1  1-cycle pulse, one per frame
//  dir         in   2  move direction, sampled in MOVE: 0 +x, 1 -x, 2 +y, 3 -y
//  color_obs   in   8  frame-buffer pixel at (x,y), valid 1 clk after x/y presented
//  x           out  8  pixel column
//  y           out  8  pixel row
//  color_draw  out  8  pixel colour, meaningful when plot=1
//  plot        out  1  write strobe, one pixel per clk
//  busy        out  1  high in every state except IDLE and WAIT
//  collide     out  1  registered; set in MOVE if move blocked, cleared by next MOVE
//  state       out  5  current state code (debug)
// BEHAVIOUR
//  Reset: state=IDLE, pos_x=pos_y=0, x=y=0, color_draw=0, plot=0, busy=0, collide=0.
//  All outputs registered. States (code): IDLE 0, DRAW 1, WAIT 2, ERASE 3, MOVE 4,
//   PROBE 5, PROBE_END 6; codes 7..31 unused, go to IDLE.
//  Scan (ERASE/DRAW/PROBE): counters cx 0..SPR_W-1 inner, cy 0..SPR_H-1 outer, 1 pixel/clk.
//   x = base_x+cx, y = base_y+cy; exactly SPR_W*SPR_H cycles per scan.
//  IDLE: start=1 -> DRAW at (pos_x,pos_y).
//  DRAW: plot=1, color_draw=FG_COLOR, base=pos; after last pixel -> WAIT.
//  WAIT: plot=0. stop=1 -> IDLE (stop wins over same-cycle frame_tick).
//   Otherwise frame_tick=1 -> ERASE.
//  ERASE: plot=1, color_draw=BG_COLOR, base=pos; after last pixel -> MOVE.
//  MOVE (1 clk): compute candidate (nx,ny) from dir.
//   Valid pos range: 0..X_MAX-SPR_W+1 (x), 0..Y_MAX-SPR_H+1 (y).
//   Out of range (incl. 0-1 underflow) -> collide=1, pos kept, -> DRAW.
//   Otherwise collide=0, -> PROBE.
//  PROBE: plot=0, base=(nx,ny); blocked flag cleared on entry.
//   Each cycle after the first samples color_obs for the previous address;
//   color_obs!=BG_COLOR sets blocked. After last address -> PROBE_END.
//  PROBE_END (1 clk): sample final pixel. blocked=0 -> pos=(nx,ny); else collide=1.
//   -> DRAW either way.
//  Sprite erased before probe, so no self-collision. frame_tick outside WAIT ignored, not queued.
//  Per move: W*H (erase) + 1 + W*H+1 (probe) + W*H (draw) clks; blocked at edge skips probe.
//  reset low mid-scan: immediate return to reset values; partially drawn pixels not cleaned.
//  Arithmetic 8-bit unsigned; candidate computed 9-bit to detect overflow/underflow.
// TESTING
//  T1 reset low 3 clk, start=1 -> 16 plots FG at (0..3,0..3) row-major, then WAIT, busy=0.
//  T2 pos(10,10), dir=0, tick, color_obs=0 -> erase (10..13,10..13), 16 probe reads
//     at (11..14,10..13), redraw at x=11..14; collide=0; 50 clk tick-to-WAIT.
//  T3 pos(10,10), dir=0, color_obs=8'h1C only at (14,12) -> collide=1, redraw at (10,10).
//  T4 pos(0,0), dir=1 -> MOVE sets collide=1, no PROBE cycles, redraw at (0,0).
//     pos(156,116), dir=0 -> blocked likewise.
//  T5 WAIT with stop=1 and frame_tick=1 same clk -> IDLE, no plot.
//     Extra frame_tick during ERASE -> exactly one move.
//  T6 reset low at 5th DRAW pixel -> next clk plot=0, x=y=0, state=0; start restarts cleanly.

Source files
------------

// File: rtl/sprite_draw_ctrl.sv
// Box-sprite sequencer: draws, erases, probes and redraws one SPR_W x SPR_H sprite per frame,
// emitting one pixel address (and optional write strobe) per clock toward the frame buffer.
module sprite_draw_ctrl #(
  parameter int unsigned SPR_W    = 4,
  parameter int unsigned SPR_H    = 4,
  parameter int unsigned X_MAX    = 159,
  parameter int unsigned Y_MAX    = 119,
  parameter logic [7:0]  BG_COLOR = 8'h00,
  parameter logic [7:0]  FG_COLOR = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       frame_tick,
  input  logic [1:0] dir,
  input  logic [7:0] color_obs,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] color_draw,
  output logic       plot,
  output logic       busy,
  output logic       collide,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,
    S_DRAW      = 5'd1,
    S_WAIT      = 5'd2,
    S_ERASE     = 5'd3,
    S_MOVE      = 5'd4,
    S_PROBE     = 5'd5,
    S_PROBE_END = 5'd6
  } state_t;

  localparam logic [8:0] X_LIM   = 9'(X_MAX - SPR_W + 1);
  localparam logic [8:0] Y_LIM   = 9'(Y_MAX - SPR_H + 1);
  localparam logic [3:0] CX_LAST = 4'(SPR_W - 1);
  localparam logic [3:0] CY_LAST = 4'(SPR_H - 1);

  state_t     r_state;
  logic [7:0] r_pos_x, r_pos_y;
  logic [7:0] r_base_x, r_base_y;
  logic [3:0] r_cx, r_cy;
  logic [7:0] r_x, r_y, r_color;
  logic       r_plot, r_busy, r_collide, r_blocked;

  logic       w_last, w_first, w_hit, w_cand_ok;
  logic [3:0] w_cx_nxt, w_cy_nxt;
  logic [7:0] w_scan_x, w_scan_y;
  logic [8:0] w_cand_x, w_cand_y;

  always_comb begin
    w_last   = (r_cx == CX_LAST) && (r_cy == CY_LAST);
    w_first  = (r_cx == '0) && (r_cy == '0);
    w_cx_nxt = (r_cx == CX_LAST) ? '0 : r_cx + 4'd1;
    w_cy_nxt = (r_cx == CX_LAST) ? r_cy + 4'd1 : r_cy;
    w_scan_x = r_base_x + {4'b0000, w_cx_nxt};
    w_scan_y = r_base_y + {4'b0000, w_cy_nxt};
    w_hit    = (color_obs != BG_COLOR);
  end

  // 9-bit candidate: a step below 0 wraps to 9'h1FF and fails the range test
  always_comb begin
    w_cand_x = {1'b0, r_pos_x};
    w_cand_y = {1'b0, r_pos_y};
    case (dir)
      2'd0:    w_cand_x = {1'b0, r_pos_x} + 9'd1;
      2'd1:    w_cand_x = {1'b0, r_pos_x} - 9'd1;
      2'd2:    w_cand_y = {1'b0, r_pos_y} + 9'd1;
      default: w_cand_y = {1'b0, r_pos_y} - 9'd1;
    endcase
    w_cand_ok = (w_cand_x <= X_LIM) && (w_cand_y <= Y_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_base_x  <= '0;
      r_base_y  <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_collide <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_state  <= S_DRAW;
            r_base_x <= r_pos_x;
            r_base_y <= r_pos_y;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x      <= r_pos_x;
            r_y      <= r_pos_y;
            r_color  <= FG_COLOR;
            r_plot   <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        S_DRAW: begin
          if (w_last) begin
            r_state <= S_WAIT;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cx <= w_cx_nxt;
            r_cy <= w_cy_nxt;
            r_x  <= w_scan_x;
            r_y  <= w_scan_y;
          end
        end

        S_WAIT: begin
          r_plot <= 1'b0;
          if (stop) begin
            r_state <= S_IDLE;
          end else if (frame_tick) begin
            r_state  <= S_ERASE;
            r_base_x <= r_pos_x;
            r_base_y <= r_pos_y;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x      <= r_pos_x;
            r_y      <= r_pos_y;
            r_color  <= BG_COLOR;
            r_plot   <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        S_ERASE: begin
          if (w_last) begin
            r_state <= S_MOVE;
            r_plot  <= 1'b0;
          end else begin
            r_cx <= w_cx_nxt;
            r_cy <= w_cy_nxt;
            r_x  <= w_scan_x;
            r_y  <= w_scan_y;
          end
        end

        S_MOVE: begin
          r_cx <= '0;
          r_cy <= '0;
          if (!w_cand_ok) begin
            r_collide <= 1'b1;
            r_state   <= S_DRAW;
            r_base_x  <= r_pos_x;
            r_base_y  <= r_pos_y;
            r_x       <= r_pos_x;
            r_y       <= r_pos_y;
            r_color   <= FG_COLOR;
            r_plot    <= 1'b1;
          end else begin
            r_collide <= 1'b0;
            r_blocked <= 1'b0;
            r_state   <= S_PROBE;
            r_base_x  <= w_cand_x[7:0];
            r_base_y  <= w_cand_y[7:0];
            r_x       <= w_cand_x[7:0];
            r_y       <= w_cand_y[7:0];
          end
        end

        // color_obs lags the address by one clock, so cycle k judges pixel k-1
        S_PROBE: begin
          if (!w_first && w_hit) r_blocked <= 1'b1;
          if (w_last) begin
            r_state <= S_PROBE_END;
          end else begin
            r_cx <= w_cx_nxt;
            r_cy <= w_cy_nxt;
            r_x  <= w_scan_x;
            r_y  <= w_scan_y;
          end
        end

        S_PROBE_END: begin
          r_state <= S_DRAW;
          r_cx    <= '0;
          r_cy    <= '0;
          r_color <= FG_COLOR;
          r_plot  <= 1'b1;
          if (r_blocked || w_hit) begin
            r_collide <= 1'b1;
            r_base_x  <= r_pos_x;
            r_base_y  <= r_pos_y;
            r_x       <= r_pos_x;
            r_y       <= r_pos_y;
          end else begin
            r_pos_x <= r_base_x;
            r_pos_y <= r_base_y;
            r_x     <= r_base_x;
            r_y     <= r_base_y;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign color_draw = r_color;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign collide    = r_collide;
  assign state      = r_state;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Bench for sprite_draw_ctrl: frame-buffer model with one-clock read latency, a
// position/obstacle reference model, directed vector table and random moves.
module tb_sprite_draw_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int XM = 159;
  localparam int YM = 119;
  localparam int BG = 8'h00;
  localparam int FG = 8'hE0;

  logic       clk = 1'b0;
  logic       reset, start, stop, frame_tick;
  logic [1:0] dir;
  logic [7:0] color_obs;
  logic [7:0] x, y, color_draw;
  logic       plot, busy, collide;
  logic [4:0] state;

  always #5 clk = ~clk;

  sprite_draw_ctrl #(
    .SPR_W(W), .SPR_H(H), .X_MAX(XM), .Y_MAX(YM),
    .BG_COLOR(8'h00), .FG_COLOR(8'hE0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .frame_tick(frame_tick), .dir(dir), .color_obs(color_obs),
    .x(x), .y(y), .color_draw(color_draw), .plot(plot),
    .busy(busy), .collide(collide), .state(state)
  );

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {logic [1:0] d; int reps; bit place_obs; int ex; int ey; int ecol;} vec_t;

  pix_t       plot_q[$];
  pix_t       probe_q[$];
  logic [7:0] fb [0:119][0:159];
  logic [7:0] obs[0:119][0:159];
  int errors = 0;
  int checks = 0;
  int cur_x = 0;
  int cur_y = 0;
  vec_t tbl[14];

  // Frame buffer: read data for the address seen last cycle, writes on plot
  initial begin : mem_model
    int px, py;
    px = 0;
    py = 0;
    color_obs = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      color_obs = fb[py][px];
      if (plot) begin
        plot_q.push_back('{int'(x), int'(y), int'(color_draw)});
        if (x < 8'd160 && y < 8'd120) fb[y][x] = color_draw;
      end
      if (state == 5'd5) probe_q.push_back('{int'(x), int'(y), 0});
      px = (x < 8'd160) ? int'(x) : 0;
      py = (y < 8'd120) ? int'(y) : 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int scan_bad(input int s, input int bx, input int by, input int c,
                                  input bit use_probe);
    int bad = 0;
    pix_t p;
    for (int k = 0; k < W * H; k++) begin
      p = use_probe ? probe_q[s + k] : plot_q[s + k];
      if (p.x != bx + k % W || p.y != by + k / W || (c >= 0 && p.c != c)) bad++;
    end
    return bad;
  endfunction

  task automatic draw_session(input string nm);
    int n = 0;
    plot_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (state != 5'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " reach_wait"}, int'(state), 2);
    chk({nm, " busy_in_wait"}, int'(busy), 0);
    chk({nm, " plot_count"}, plot_q.size(), W * H);
    if (plot_q.size() == W * H) chk({nm, " draw_trace"}, scan_bad(0, cur_x, cur_y, FG, 0), 0);
  endtask

  task automatic run_move(input logic [1:0] d, input bit extra, output int dx, output int dy);
    int nx, ny, ex, ey, n, bcnt;
    bit eprobe, blk;
    nx = cur_x + ((d == 2'd0) ? 1 : 0) - ((d == 2'd1) ? 1 : 0);
    ny = cur_y + ((d == 2'd2) ? 1 : 0) - ((d == 2'd3) ? 1 : 0);
    eprobe = (nx >= 0 && nx <= XM - W + 1 && ny >= 0 && ny <= YM - H + 1);
    blk = !eprobe;
    if (eprobe)
      for (int j = 0; j < H; j++)
        for (int i = 0; i < W; i++)
          if (obs[ny + j][nx + i] != 8'h00) blk = 1'b1;
    ex = blk ? cur_x : nx;
    ey = blk ? cur_y : ny;

    chk("move_from_wait", int'(state), 2);
    plot_q.delete();
    probe_q.delete();
    dir = d;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bcnt = busy ? 1 : 0;
    n = 0;
    while (state != 5'd2 && n < 300) begin
      frame_tick = (extra && n == 3);
      @(negedge clk);
      n++;
      if (busy) bcnt++;
    end
    frame_tick = 1'b0;
    chk("move_reach_wait", int'(state), 2);
    if (extra) begin
      repeat (4) @(negedge clk);
      chk("single_move_only", int'(state), 2);
      chk("single_move_plots", plot_q.size(), 2 * W * H);
    end
    chk("collide", int'(collide), blk ? 1 : 0);
    chk("busy_cycles", bcnt, eprobe ? 3 * W * H + 2 : 2 * W * H + 1);
    chk("plot_count", plot_q.size(), 2 * W * H);
    if (plot_q.size() == 2 * W * H) begin
      chk("erase_trace", scan_bad(0, cur_x, cur_y, BG, 0), 0);
      chk("redraw_trace", scan_bad(W * H, ex, ey, FG, 0), 0);
    end
    chk("probe_count", probe_q.size(), eprobe ? W * H : 0);
    if (eprobe && probe_q.size() == W * H) chk("probe_addr", scan_bad(0, nx, ny, -1, 1), 0);
    dx = (plot_q.size() > W * H) ? plot_q[W * H].x : -1;
    dy = (plot_q.size() > W * H) ? plot_q[W * H].y : -1;
    cur_x = ex;
    cur_y = ey;
  endtask

  initial begin : main
    int dx, dy, ox, oy;
    tbl[0]  = '{2'd1,   1, 1'b0,   0,   0, 1};
    tbl[1]  = '{2'd3,   1, 1'b0,   0,   0, 1};
    tbl[2]  = '{2'd0,  10, 1'b0,  10,   0, 0};
    tbl[3]  = '{2'd2,  10, 1'b0,  10,  10, 0};
    tbl[4]  = '{2'd0,   1, 1'b0,  11,  10, 0};
    tbl[5]  = '{2'd1,   1, 1'b0,  10,  10, 0};
    tbl[6]  = '{2'd0,   1, 1'b1,  10,  10, 1};
    tbl[7]  = '{2'd1,   1, 1'b0,   9,  10, 0};
    tbl[8]  = '{2'd0,   1, 1'b0,  10,  10, 0};
    tbl[9]  = '{2'd2, 106, 1'b0,  10, 116, 0};
    tbl[10] = '{2'd0, 146, 1'b0, 156, 116, 0};
    tbl[11] = '{2'd0,   1, 1'b0, 156, 116, 1};
    tbl[12] = '{2'd2,   1, 1'b0, 156, 116, 1};
    tbl[13] = '{2'd3,   1, 1'b0, 156, 115, 0};

    for (int j = 0; j < 120; j++)
      for (int i = 0; i < 160; i++) begin
        fb[j][i]  = 8'h00;
        obs[j][i] = 8'h00;
      end
    reset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    frame_tick = 1'b0;
    dir = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_color", int'(color_draw), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_collide", int'(collide), 0);
    reset = 1'b1;
    @(negedge clk);

    draw_session("first_draw");

    plot_q.delete();
    stop = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    frame_tick = 1'b0;
    chk("stop_wins_state", int'(state), 0);
    chk("stop_wins_plot", plot_q.size(), 0);
    chk("stop_idle_busy", int'(busy), 0);
    draw_session("restart_draw");

    run_move(2'd0, 1'b1, dx, dy);
    chk("extra_tick_pos_x", dx, 1);
    run_move(2'd1, 1'b0, dx, dy);
    chk("back_home_x", dx, 0);

    foreach (tbl[i]) begin
      if (tbl[i].place_obs) begin
        obs[12][14] = 8'h1C;
        fb[12][14]  = 8'h1C;
      end
      for (int r = 0; r < tbl[i].reps; r++) run_move(tbl[i].d, 1'b0, dx, dy);
      chk($sformatf("tbl%0d_x", i), dx, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), dy, tbl[i].ey);
      chk($sformatf("tbl%0d_collide", i), int'(collide), tbl[i].ecol);
    end

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(2, 0) == 0) begin
        ox = int'($urandom_range(159, 12));
        oy = int'($urandom_range(119, 12));
        if (!(ox >= cur_x && ox < cur_x + W && oy >= cur_y && oy < cur_y + H)) begin
          obs[oy][ox] = 8'($urandom_range(255, 1));
          fb[oy][ox]  = obs[oy][ox];
        end
      end
      run_move(2'($urandom_range(3, 0)), 1'b0, dx, dy);
    end

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_to_idle", int'(state), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("fifth_px_x", int'(x), cur_x);
    chk("fifth_px_y", int'(y), cur_y + 1);
    chk("fifth_px_plot", int'(plot), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midscan_rst_plot", int'(plot), 0);
    chk("midscan_rst_x", int'(x), 0);
    chk("midscan_rst_y", int'(y), 0);
    chk("midscan_rst_state", int'(state), 0);
    reset = 1'b1;
    cur_x = 0;
    cur_y = 0;
    for (int j = 0; j < 120; j++)
      for (int i = 0; i < 160; i++) fb[j][i] = obs[j][i];
    @(negedge clk);
    draw_session("post_reset_draw");
    run_move(2'd0, 1'b0, dx, dy);
    chk("post_reset_move_x", dx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
